vga_frame_store: RTL
====================

Name: vga_frame_store

Overview:
- Synthesizable, parametrised successor to the simulation-only pixel frame buffer in the VGA card.
- Sits between the host pixel-write interface and the VGA timing generator.
- Stores H_WIDTH x V_WIDTH pixels of packed RGB and serves them to the scan-out path with fixed 2-cycle latency.
- Clears itself after reset and range-checks both ports.

Parameters:
H_WIDTH, 200, pixels per line stored
V_WIDTH, 600, lines stored
R_DEPTH, 2, red bits per pixel
G_DEPTH, 2, green bits per pixel
B_DEPTH, 2, blue bits per pixel
H_BITS, 9, width of horizontal index/coordinate
V_BITS, 10, width of vertical index/coordinate
CLEAR_COLOR, 0, pixel value written to every address by the post-reset clear sweep
BORDER_COLOR, 0, pixel value output for in-display but out-of-range read coordinates

Ports:
clk  input  1  single system/pixel clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
disp_en  input  1  active-video strobe from timing generator (high outside porch/sync)
frame_start  input  1  one-cycle pulse at first pixel of each frame
h_index  input  H_BITS  scan-out column
v_index  input  V_BITS  scan-out line
wr_valid  input  1  host write request
wr_ready  output  1  block can accept a write this cycle
wr_x  input  H_BITS  write column
wr_y  input  V_BITS  write line
wr_data  input  COLOR_BITS  write pixel (COLOR_BITS = R_DEPTH+G_DEPTH+B_DEPTH)
wr_err  output  1  one-cycle pulse: accepted write was out of range and dropped
color_out  output  COLOR_BITS  scan-out pixel
color_valid  output  1  color_out corresponds to an active-video pixel
init_done  output  1  clear sweep finished
swap_req  input  1  request buffer swap (FB_DOUBLE_BUFFER_EN only)
swap_done  output  1  one-cycle pulse when swap takes effect (FB_DOUBLE_BUFFER_EN only)

Behaviour:
- Async reset values: color_out=0, color_valid=0, wr_ready=0, wr_err=0, init_done=0, swap_done=0. Pipeline valid bits clear, FSM enters CLEAR, clear counter=0.
- Address is y*H_WIDTH + x, computed at full ADDR_BITS = clog2(H_WIDTH*V_WIDTH) width. No truncation.
- In range means x < H_WIDTH and y < V_WIDTH. Both checks are done on the raw index, never on the computed address.
- FSM states:
  - CLEAR: write CLEAR_COLOR to counter address, one per cycle. wr_ready=0. Go to RUN after writing address H_WIDTH*V_WIDTH-1.
  - RUN: init_done=1, wr_ready=1.
  - Reset asserted in any state returns to CLEAR and restarts the sweep from 0.
- Write handshake:
  - Transfer occurs when wr_valid && wr_ready. Memory is updated at that edge.
  - Out-of-range transfer is consumed, not stored, and wr_err=1 the following cycle only.
  - wr_valid while wr_ready=0 is ignored. The host must hold it.
- Read pipeline, latency 2:
  - Stage 1 registers address, in-range flag and disp_en.
  - Stage 2 registers the memory read.
  - color_valid = disp_en delayed 2 cycles, forced 0 while FSM=CLEAR.
  - color_out = memory data if stage-2 valid and in range; BORDER_COLOR if valid and out of range; 0 if not valid.
- Read/write collision on the same address in the same cycle: the read returns the old data. The write is visible to reads issued the next cycle or later.

Optional Feature:
FB_DOUBLE_BUFFER_EN
- Defined:
  - Memory depth is 2x, with a front/back select bit (reset: front=bank 0).
  - Scan-out reads the front bank; host writes go to the back bank.
  - swap_req sets a sticky pending flag.
  - On frame_start with pending set, the bank select toggles that edge, pending clears, and swap_done pulses the next cycle.
  - swap_req coincident with frame_start swaps at that frame_start.
  - The clear sweep covers both banks, taking 2*H_WIDTH*V_WIDTH cycles.
- Undefined:
  - Single bank.
  - swap_req ignored; swap_done tied 0.
  - Writes are visible to scan-out directly.

Test Plan:
- Release rst_n -> wr_ready=0 for exactly 120000 cycles, then wr_ready=1 and init_done=1. Reading any in-range pixel returns 0x00.
- Write (x=5,y=3,data=0x2A), then scan h=5,v=3 with disp_en=1 -> color_out=0x2A, color_valid=1 exactly 2 cycles after the index is presented.
- Write x=200,y=0 -> handshake completes, wr_err pulses 1 cycle, and no memory address changes (spot-check addr 0 and 199). Read h=250,v=10 with disp_en -> BORDER_COLOR.
- Same-cycle write 0x15 and read at (0,0) holding 0x00 -> read returns 0x00; next-cycle read returns 0x15.
- Assert rst_n low mid-sweep at cycle 500 -> all outputs return to reset values; the sweep restarts at address 0 and takes a full 120000 cycles.
- FB_DOUBLE_BUFFER_EN: write 0x3F to (1,1) -> scan reads 0x00. Assert swap_req, then frame_start -> swap_done 1 cycle later, and scan of (1,1) returns 0x3F.

Source files
------------

// File: rtl/vga_frame_store_if.sv
// Host pixel-write channel of the VGA frame store: valid/ready handshake
// with an out-of-range error pulse returned to the host.
interface vga_frame_store_if #(
    parameter int H_BITS     = 9,
    parameter int V_BITS     = 10,
    parameter int COLOR_BITS = 6
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [H_BITS-1:0]     wr_x;
    logic [V_BITS-1:0]     wr_y;
    logic [COLOR_BITS-1:0] wr_data;
    logic                  wr_err;

    modport master (
        output wr_valid, wr_x, wr_y, wr_data,
        input  wr_ready, wr_err
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_data,
        output wr_ready, wr_err
    );
endinterface

// File: rtl/vga_frame_store.sv
// VGA pixel frame store: self-clearing RGB memory with a 2-cycle scan-out read.
// Define FB_DOUBLE_BUFFER_EN for front/back banks swapped on frame_start.
module vga_frame_store #(
    parameter int H_WIDTH = 200,
    parameter int V_WIDTH = 600,
    parameter int R_DEPTH = 2,
    parameter int G_DEPTH = 2,
    parameter int B_DEPTH = 2,
    parameter int H_BITS  = 9,
    parameter int V_BITS  = 10,
    parameter logic [R_DEPTH+G_DEPTH+B_DEPTH-1:0] CLEAR_COLOR  = '0,
    parameter logic [R_DEPTH+G_DEPTH+B_DEPTH-1:0] BORDER_COLOR = '0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                disp_en,
    input  logic                                frame_start,
    input  logic [H_BITS-1:0]                   h_index,
    input  logic [V_BITS-1:0]                   v_index,
    vga_frame_store_if.slave                    wr_bus,
    output logic [R_DEPTH+G_DEPTH+B_DEPTH-1:0]  color_out,
    output logic                                color_valid,
    output logic                                init_done,
    input  logic                                swap_req,
    output logic                                swap_done
);

    localparam int COLOR_BITS = R_DEPTH + G_DEPTH + B_DEPTH;
    localparam int PIXELS     = H_WIDTH * V_WIDTH;
    localparam int ADDR_BITS  = $clog2(PIXELS);
`ifdef FB_DOUBLE_BUFFER_EN
    localparam int MEM_DEPTH  = 2 * PIXELS;
`else
    localparam int MEM_DEPTH  = PIXELS;
`endif
    localparam int MEM_BITS   = $clog2(MEM_DEPTH);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                 state;
    state_t                 next_state;
    logic [MEM_BITS-1:0]    clear_addr;
    logic                   clear_last;
    logic                   rd_bank;
    logic                   wr_bank;

    logic                   wr_in_range;
    logic                   rd_in_range;
    logic                   wr_fire;
    logic                   wq_valid;
    logic [MEM_BITS-1:0]    wq_addr;
    logic [COLOR_BITS-1:0]  wq_data;
    logic                   wr_err_q;

    logic                   s1_en;
    logic                   s1_in_range;
    logic [MEM_BITS-1:0]    s1_addr;
    logic                   s2_en;
    logic                   s2_in_range;
    logic [COLOR_BITS-1:0]  rd_data;
    logic [COLOR_BITS-1:0]  mem [MEM_DEPTH];

    // Linear pixel address y*H_WIDTH+x, offset into the upper half for bank 1
    function automatic logic [MEM_BITS-1:0] mem_addr(input logic bank,
                                                     input logic [H_BITS-1:0] x,
                                                     input logic [V_BITS-1:0] y);
        logic [ADDR_BITS-1:0] pix;
        pix = ADDR_BITS'(y) * ADDR_BITS'(H_WIDTH) + ADDR_BITS'(x);
        return bank ? (MEM_BITS'(pix) + MEM_BITS'(PIXELS)) : MEM_BITS'(pix);
    endfunction

    assign clear_last  = (clear_addr == MEM_BITS'(MEM_DEPTH - 1));
    assign wr_in_range = (wr_bus.wr_x < H_BITS'(H_WIDTH)) && (wr_bus.wr_y < V_BITS'(V_WIDTH));
    assign rd_in_range = (h_index < H_BITS'(H_WIDTH)) && (v_index < V_BITS'(V_WIDTH));
    assign wr_fire     = wr_bus.wr_valid && wr_bus.wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (clear_last) next_state = RUN;
            RUN:     next_state = RUN;
            default: next_state = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_addr <= '0;
        end else if (state == CLEAR && !clear_last) begin
            clear_addr <= clear_addr + MEM_BITS'(1);
        end
    end

    assign wr_bus.wr_ready = (state == RUN);
    assign wr_bus.wr_err   = wr_err_q;
    assign init_done       = (state == RUN);

`ifdef FB_DOUBLE_BUFFER_EN
    logic front;
    logic swap_pending;
    logic swap_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front        <= 1'b0;
            swap_pending <= 1'b0;
            swap_done_q  <= 1'b0;
        end else begin
            swap_done_q <= 1'b0;
            if (frame_start && (swap_pending || swap_req)) begin
                front        <= ~front;
                swap_pending <= 1'b0;
                swap_done_q  <= 1'b1;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

    assign rd_bank   = front;
    assign wr_bank   = ~front;
    assign swap_done = swap_done_q;
`else
    logic unused_swap;
    assign unused_swap = swap_req ^ frame_start;
    assign rd_bank     = 1'b0;
    assign wr_bank     = 1'b0;
    assign swap_done   = 1'b0;
`endif

    // Host writes commit one edge after the handshake, so a same-cycle read sees old data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wq_valid <= 1'b0;
            wq_addr  <= '0;
            wq_data  <= '0;
            wr_err_q <= 1'b0;
        end else begin
            wq_valid <= wr_fire && wr_in_range;
            wq_addr  <= mem_addr(wr_bank, wr_bus.wr_x, wr_bus.wr_y);
            wq_data  <= wr_bus.wr_data;
            wr_err_q <= wr_fire && !wr_in_range;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_en       <= 1'b0;
            s1_in_range <= 1'b0;
            s1_addr     <= '0;
            s2_en       <= 1'b0;
            s2_in_range <= 1'b0;
        end else begin
            s1_en       <= disp_en;
            s1_in_range <= rd_in_range;
            s1_addr     <= rd_in_range ? mem_addr(rd_bank, h_index, v_index) : '0;
            s2_en       <= s1_en;
            s2_in_range <= s1_in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clear_addr] <= CLEAR_COLOR;
        end else if (wq_valid) begin
            mem[wq_addr] <= wq_data;
        end
        rd_data <= mem[s1_addr];
    end

    assign color_valid = s2_en && (state == RUN);
    assign color_out   = !color_valid ? '0 : (s2_in_range ? rd_data : BORDER_COLOR);

endmodule
